fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of cpu_core.
- Drives a synchronous program memory (1-cycle read latency).
- Buffers fetched 16-bit instructions, each tagged with its PC, in a small FIFO.
- Presents instructions to the core over a valid/ready handshake. A redirect from the core (taken branch) flushes the queue and restarts fetch at the target.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side widths and the fetch queue entry format.
// The entry pairs an instruction word with the PC it was fetched from.
package cpu_pkg;

    localparam int CPU_PC_WIDTH    = 8;
    localparam int CPU_INSTR_WIDTH = 16;

    typedef struct packed {
        logic [CPU_INSTR_WIDTH-1:0] instr;
        logic [CPU_PC_WIDTH-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and an occupancy count.
// The head entry is read straight from storage; a push is never visible at the head in the same cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // Flush dominates any push or pop presented in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_C);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues reads to a 1-cycle program memory and queues returned
// instructions with their PCs; a redirect flushes everything and restarts at the target.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   pm_rd_en,
    output logic [PC_WIDTH-1:0]    pm_addr,
    input  logic [INSTR_WIDTH-1:0] pm_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    fetch_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;
    logic                inflight_q, inflight_d;
    logic [CW-1:0]       count;
    logic [CW-1:0]       occupancy;
    logic                head_valid, pop, push, issue;
    fetch_entry_t        head, push_entry;

    // Handshake: the head transfers on a cycle where instr_valid and instr_ready are both high
    // and no redirect is present; instr/instr_pc stay stable until that transfer happens.
    assign head_valid = (count != '0);
    assign pop        = head_valid & instr_ready & ~redirect;

    // Reserve a slot for every read in flight so a returning word always has room.
    assign occupancy  = count - CW'(pop) + CW'(inflight_q);
    assign issue      = reset & ~redirect & (occupancy < DEPTH_C);
    assign push       = inflight_q & ~redirect;
    assign push_entry = '{instr: pm_rdata, pc: issue_pc_q};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
            issue_pc_d = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= '0;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (count),
        .head_o      (head)
    );

    assign pm_rd_en    = issue;
    assign pm_addr     = fetch_pc_q;
    assign fetch_pc    = fetch_pc_q;
    assign instr_valid = reset & head_valid;
    assign instr       = reset ? head.instr : '0;
    assign instr_pc    = reset ? head.pc : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a behavioural 1-cycle program ROM holding 0x1000+addr.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pm_rd_en;
    logic [7:0]  pm_addr;
    logic [15:0] pm_rdata = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [7:0]  fetch_pc;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] rom [256];
    logic [7:0]  exp_pc;
    logic [15:0] exp_in;
    logic        exp_v;
    logic        exp_rd;

    always #5 clock = ~clock;

    initial for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);

    always @(posedge clock) if (pm_rd_en) pm_rdata <= rom[pm_addr];

    fetch_queue u_dut (
        .clock       (clock),
        .reset       (reset),
        .pm_rd_en    (pm_rd_en),
        .pm_addr     (pm_addr),
        .pm_rdata    (pm_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc)
    );

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (just after reset release, before the first edge).
    task automatic do_reset(input logic rdy);
        @(negedge clock);
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = rdy;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_assert++;
        if ({instr_valid, pm_rd_en, fetch_pc, instr_pc, instr} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b rd=%b fpc=%h pc=%h i=%h, want all 0",
                     instr_valid, pm_rd_en, fetch_pc, instr_pc, instr);
        end
        repeat (2) @(posedge clock);
        #1;
        n_assert++;
        if ({instr_valid, pm_rd_en, fetch_pc} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got v=%b rd=%b fpc=%h, want 0 0 00", instr_valid, pm_rd_en, fetch_pc);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        n_assert++;
        if (pm_rd_en !== 1'b1 || pm_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL stream_first_read: got rd=%b addr=%h, want 1 00", pm_rd_en, pm_addr);
        end
        for (int c = 0; c < 10; c++) begin
            exp_v  = (c >= 2);
            exp_pc = 8'(c - 2);
            exp_in = 16'h1000 + {8'h00, exp_pc};
            n_assert++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== exp_pc || instr !== exp_in))) begin
                n_fail++;
                $display("FAIL stream_head c=%0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, exp_v, exp_pc, exp_in);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c == 10) instr_ready = 1'b1;
            #1;
            exp_rd = (c <= 3) || (c >= 10);
            n_assert++;
            if (pm_rd_en !== exp_rd) begin
                n_fail++;
                $display("FAIL bp_rd_en c=%0d: got %b want %b", c, pm_rd_en, exp_rd);
            end
            exp_v  = (c >= 2);
            exp_pc = (c < 10) ? 8'h00 : 8'(c - 10);
            exp_in = 16'h1000 + {8'h00, exp_pc};
            n_assert++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== exp_pc || instr !== exp_in))) begin
                n_fail++;
                $display("FAIL bp_head c=%0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, exp_v, exp_pc, exp_in);
            end
            if (c == 9) begin
                n_assert++;
                if (fetch_pc !== 8'h04) begin
                    n_fail++;
                    $display("FAIL bp_fetch_pc: got %h want 04", fetch_pc);
                end
            end
            next_cycle();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        do_reset(1'b0);
        repeat (4) next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'h20;
        #1;
        n_assert++;
        if (pm_rd_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_redirect_cycle: got rd=%b v=%b pc=%h, want 0 1 00", pm_rd_en, instr_valid, instr_pc);
        end
        next_cycle();
        redirect = 1'b0;
        #1;
        n_assert++;
        if (instr_valid !== 1'b0 || pm_rd_en !== 1'b1 || pm_addr !== 8'h20 || fetch_pc !== 8'h20) begin
            n_fail++;
            $display("FAIL flush_restart: got v=%b rd=%b addr=%h fpc=%h, want 0 1 20 20",
                     instr_valid, pm_rd_en, pm_addr, fetch_pc);
        end
        next_cycle();
        n_assert++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_gap: got v=%b want 0", instr_valid);
        end
        next_cycle();
        n_assert++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h20 || instr !== 16'h1020) begin
            n_fail++;
            $display("FAIL flush_first: got v=%b pc=%h i=%h, want 1 20 1020", instr_valid, instr_pc, instr);
        end
        instr_ready = 1'b1;
        next_cycle();
        n_assert++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h21 || instr !== 16'h1021) begin
            n_fail++;
            $display("FAIL flush_second: got v=%b pc=%h i=%h, want 1 21 1021", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_redirect_ready();
        do_reset(1'b1);
        repeat (5) next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        #1;
        n_assert++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h03 || pm_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_redirect_cycle: got v=%b pc=%h rd=%b, want 1 03 0", instr_valid, instr_pc, pm_rd_en);
        end
        next_cycle();
        redirect = 1'b0;
        for (int c = 6; c < 10; c++) begin
            #1;
            exp_v  = (c >= 8);
            exp_pc = 8'(8'h40 + c - 8);
            exp_in = 16'h1000 + {8'h00, exp_pc};
            n_assert++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== exp_pc || instr !== exp_in))) begin
                n_fail++;
                $display("FAIL rdy_after c=%0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, exp_v, exp_pc, exp_in);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        repeat (3) next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'h50;
        next_cycle();
        redirect_pc = 8'h60;
        next_cycle();
        redirect = 1'b0;
        #1;
        n_assert++;
        if (instr_valid !== 1'b0 || pm_addr !== 8'h60 || fetch_pc !== 8'h60) begin
            n_fail++;
            $display("FAIL b2b_target: got v=%b addr=%h fpc=%h, want 0 60 60", instr_valid, pm_addr, fetch_pc);
        end
        repeat (2) next_cycle();
        n_assert++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h60 || instr !== 16'h1060) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b pc=%h i=%h, want 1 60 1060", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        repeat (3) next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        next_cycle();
        redirect = 1'b0;
        for (int c = 4; c < 10; c++) begin
            #1;
            exp_v  = (c >= 6);
            exp_pc = 8'(8'hFE + c - 6);
            exp_in = 16'h1000 + {8'h00, exp_pc};
            n_assert++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== exp_pc || instr !== exp_in))) begin
                n_fail++;
                $display("FAIL wrap c=%0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, exp_v, exp_pc, exp_in);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        repeat (5) next_cycle();
        #1;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({instr_valid, pm_rd_en, fetch_pc, instr_pc, instr} !== 34'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b rd=%b fpc=%h pc=%h i=%h, want all 0",
                     instr_valid, pm_rd_en, fetch_pc, instr_pc, instr);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            exp_v  = (c >= 2);
            exp_pc = 8'(c - 2);
            exp_in = 16'h1000 + {8'h00, exp_pc};
            n_assert++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== exp_pc || instr !== exp_in))) begin
                n_fail++;
                $display("FAIL async_restart c=%0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, exp_v, exp_pc, exp_in);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_ready();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
